// File: rtl/mod16_count_extender_if.sv
// Bus between the ripple-counter extender and its consumers.
// master drives COUNT_IN/SYNC_CLR; slave returns count and flags.
interface mod16_count_extender_if #(
  parameter int HI_WIDTH = 4
);
  logic [3:0]          COUNT_IN;
  logic                SYNC_CLR;
  logic [HI_WIDTH+3:0] EXT_COUNT;
  logic                VALID;
  logic                STEP_UP;
  logic                STEP_DN;
  logic                WRAP;
  logic                STEP_ERR;

  modport master (
    output COUNT_IN, SYNC_CLR,
    input  EXT_COUNT, VALID,
    input  STEP_UP, STEP_DN,
    input  WRAP, STEP_ERR
  );

  modport slave (
    input  COUNT_IN, SYNC_CLR,
    output EXT_COUNT, VALID,
    output STEP_UP, STEP_DN,
    output WRAP, STEP_ERR
  );
endinterface

// File: rtl/mod16_count_extender.sv
// Syncs a 4-bit ripple count, infers +/-1 steps, extends with wrap count.
// Ports: CLOCK, CLEAR (async low), bus (slave: COUNT_IN/SYNC_CLR in, count+flags out).
module mod16_count_extender #(
  parameter int HI_WIDTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic CLOCK,
  input logic CLEAR,
  mod16_count_extender_if.slave bus
);

  typedef enum logic {
    INIT,
    TRACK
  } state_e;

  localparam logic [2:0] ICNT_MAX =
    3'(SYNC_STAGES + 1);
  localparam logic [HI_WIDTH-1:0] HI_ONE = 1;

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;
  logic [3:0] q_q;
  logic       stable;
  logic [3:0] delta;

  state_e              state_q;
  logic [2:0]          icnt_q;
  logic [3:0]          cur_q;
  logic [HI_WIDTH-1:0] hi_q;
  logic                valid_q;
  logic                up_q;
  logic                dn_q;
  logic                wrap_q;
  logic                err_q;

  assign s      = sync_q[SYNC_STAGES-1];
  // a value seen on two consecutive edges is past any ripple
  assign stable = (s == q_q);
  assign delta  = s - cur_q;

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      q_q <= '0;
    end else begin
      sync_q[0] <= bus.COUNT_IN;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      q_q <= s;
    end
  end

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_q <= INIT;
      icnt_q  <= '0;
      cur_q   <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.SYNC_CLR) begin
        state_q <= INIT;
        icnt_q  <= '0;
        cur_q   <= '0;
        hi_q    <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        unique case (state_q)
          INIT: begin
            // let the sync chain flush before trusting s
            if (icnt_q != ICNT_MAX) begin
              icnt_q <= icnt_q + 3'd1;
            end else if (stable) begin
              cur_q   <= s;
              hi_q    <= '0;
              valid_q <= 1'b1;
              state_q <= TRACK;
            end
          end
          TRACK: begin
            if (stable && (s != cur_q)) begin
              cur_q <= s;
              unique case (1'b1)
                (delta == 4'd1): begin
                  up_q <= 1'b1;
                  if (cur_q == 4'hF) begin
                    hi_q   <= hi_q + HI_ONE;
                    wrap_q <= 1'b1;
                  end
                end
                (delta == 4'hF): begin
                  dn_q <= 1'b1;
                  if (cur_q == 4'h0) begin
                    hi_q   <= hi_q - HI_ONE;
                    wrap_q <= 1'b1;
                  end
                end
                default: err_q <= 1'b1;
              endcase
            end
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  assign bus.EXT_COUNT = {hi_q, cur_q};
  assign bus.VALID     = valid_q;
  assign bus.STEP_UP   = up_q;
  assign bus.STEP_DN   = dn_q;
  assign bus.WRAP      = wrap_q;
  assign bus.STEP_ERR  = err_q;

endmodule

// File: tb/tb_mod16_count_extender.sv
// Directed bench for mod16_count_extender (HI_WIDTH=4, SYNC_STAGES=2).
// Vector table for tracking plus sequences for init, clear and glitch.
module tb_mod16_count_extender;

  typedef struct {
    logic [3:0] cin;
    logic [7:0] ext;
    logic       up;
    logic       dn;
    logic       wrap;
    logic       err;
  } vec_t;

  logic CLOCK;
  logic CLEAR;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] prev_ext;
  vec_t tbl[$];

  mod16_count_extender_if #(.HI_WIDTH(4)) bus();

  mod16_count_extender #(
    .HI_WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK(CLOCK),
    .CLEAR(CLEAR),
    .bus(bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.VALID, bus.STEP_UP, bus.STEP_DN,
            bus.WRAP, bus.STEP_ERR};
  endfunction

  // called at a negedge; holds the value 5 cycles
  task automatic apply(input vec_t v);
    bus.COUNT_IN = v.cin;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("latency_hold", 32'(bus.EXT_COUNT),
        32'(prev_ext));
    @(negedge CLOCK);
    chk("ext", 32'(bus.EXT_COUNT), 32'(v.ext));
    chk("flags", 32'(flags()),
        32'({1'b1, v.up, v.dn, v.wrap, v.err}));
    @(negedge CLOCK);
    chk("pulse_clear",
        32'({bus.STEP_UP, bus.STEP_DN, bus.WRAP}), 0);
    prev_ext = v.ext;
  endtask

  task automatic do_clr(input logic [3:0] v,
                        input logic [7:0] exp);
    bit got = 0;
    bus.COUNT_IN = v;
    bus.SYNC_CLR = 1'b1;
    @(negedge CLOCK);
    bus.SYNC_CLR = 1'b0;
    chk("clr_ext", 32'(bus.EXT_COUNT), 0);
    chk("clr_flags", 32'(flags()), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK);
      if (bus.VALID) begin
        got = 1;
        break;
      end
    end
    chk("clr_revalid", 32'(got), 1);
    chk("clr_init_ext", 32'(bus.EXT_COUNT),
        32'(exp));
    chk("clr_init_err", 32'(bus.STEP_ERR), 0);
    prev_ext = exp;
  endtask

  initial begin
    bit got;
    bit bad;
    int ups;

    for (int i = 6; i < 16; i++)
      tbl.push_back('{4'(i), 8'(i), 1, 0, 0, 0});
    tbl.push_back('{4'h0, 8'h10, 1, 0, 1, 0});
    tbl.push_back('{4'h1, 8'h11, 1, 0, 0, 0});
    tbl.push_back('{4'h0, 8'h10, 0, 1, 0, 0});
    tbl.push_back('{4'hF, 8'h0F, 0, 1, 1, 0});
    tbl.push_back('{4'h3, 8'h03, 0, 0, 0, 1});
    tbl.push_back('{4'h7, 8'h07, 0, 0, 0, 1});
    tbl.push_back('{4'h8, 8'h08, 1, 0, 0, 1});

    CLEAR        = 1'b0;
    bus.COUNT_IN = 4'd5;
    bus.SYNC_CLR = 1'b0;
    repeat (3) @(negedge CLOCK);
    chk("rst_ext", 32'(bus.EXT_COUNT), 0);
    chk("rst_flags", 32'(flags()), 0);

    CLEAR = 1'b1;
    got = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      if (bus.STEP_UP || bus.STEP_DN || bus.WRAP)
        bad = 1;
      if (bus.VALID) begin
        got = 1;
        break;
      end
    end
    chk("init_valid", 32'(got), 1);
    chk("init_ext", 32'(bus.EXT_COUNT), 32'h05);
    chk("init_no_pulse", 32'(bad), 0);
    chk("init_err", 32'(bus.STEP_ERR), 0);
    prev_ext = 8'h05;

    foreach (tbl[i]) apply(tbl[i]);

    // step 8->9 collides with SYNC_CLR
    bus.COUNT_IN = 4'd9;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("pre_clr_err", 32'(bus.STEP_ERR), 1);
    do_clr(4'd9, 8'h09);

    do_clr(4'd0, 8'h00);
    apply('{4'hF, 8'hFF, 0, 1, 1, 0});
    apply('{4'h0, 8'h00, 1, 0, 1, 0});

    do_clr(4'd4, 8'h04);
    bus.COUNT_IN = 4'd9;
    @(negedge CLOCK);
    bus.COUNT_IN = 4'd5;
    ups = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK);
      if (bus.STEP_UP) ups++;
      if (bus.STEP_DN || bus.WRAP) bad = 1;
      if (bus.EXT_COUNT == 8'h09) bad = 1;
    end
    chk("glitch_ups", 32'(ups), 1);
    chk("glitch_bad", 32'(bad), 0);
    chk("glitch_ext", 32'(bus.EXT_COUNT), 32'h05);
    chk("glitch_err", 32'(bus.STEP_ERR), 0);

    #2 CLEAR = 1'b0;
    #1;
    chk("async_ext", 32'(bus.EXT_COUNT), 0);
    chk("async_flags", 32'(flags()), 0);
    @(negedge CLOCK);
    chk("hold_rst_ext", 32'(bus.EXT_COUNT), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
